// File: rtl/disp_pkg.sv
// Shared definitions for the parking-lot 7-seg display path.
// Holds the digit code width, the named letter codes and the helper
// that decides whether a code has an entry in the downstream decoder.
package disp_pkg;

    localparam int            DIG_W          = 4;
    localparam logic [3:0]    CODE_H         = 4'hA;
    localparam logic [3:0]    CODE_A         = 4'hB;
    localparam logic [3:0]    CODE_MAX       = CODE_A;
    localparam logic [3:0]    CODE_BLANK_OUT = 4'h0;

    // Codes above the last letter have no decoder entry and must stay dark.
    function automatic logic code_legal(input logic [DIG_W-1:0] code);
        return code <= CODE_MAX;
    endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Slot timing for the display scanner.
// presc counts clk cycles inside a digit slot, idx selects the digit slot.
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   synchronous active-low reset
//   idx        out  current digit slot
//   in_guard   out  current cycle is inside the anti-ghosting guard window
//   slot_end   out  last cycle of the current slot
//   frame_end  out  last cycle of the last slot (the commit cycle)
module scan_prescaler #(
    parameter int REFRESH_DIV = 50000,
    parameter int NUM_DIGITS  = 4,
    parameter int GUARD       = 2,
    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1,
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic [IW-1:0] idx,
    output logic          in_guard,
    output logic          slot_end,
    output logic          frame_end
);

    localparam logic [PW-1:0] PRESC_MAX = PW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_MAX   = IW'(NUM_DIGITS - 1);

    logic [PW-1:0] presc;

    assign slot_end  = (presc == PRESC_MAX);
    assign frame_end = slot_end && (idx == IDX_MAX);

    generate
        if (GUARD == 0) begin : g_no_guard
            assign in_guard = 1'b0;
        end else begin : g_guard
            localparam logic [PW-1:0] GUARD_C = PW'(GUARD);
            assign in_guard = (presc < GUARD_C);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc <= '0;
            idx   <= '0;
        end else if (slot_end) begin
            presc <= '0;
            idx   <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
        end else begin
            presc <= presc + 1'b1;
        end
    end

endmodule

// File: rtl/disp_scan_mux.sv
// Time-multiplexed scan driver feeding the 7-seg decoder.
// Display data is double-buffered: load captures into a pending buffer,
// which is copied to the active buffer only in the last cycle of a frame,
// so a frame never shows a mix of old and new digits.
// Ports:
//   clk         in   system clock, rising edge
//   rst_n       in   synchronous active-low reset
//   load        in   1-cycle strobe capturing digits_in/blank_in as pending
//   digits_in   in   digit i code at [4i+3:4i]
//   blank_in    in   1 = digit i dark
//   dig_out     out  code for the current slot (0 when dark)
//   an_n        out  active-low anode enables, at most one low
//   frame_done  out  1-cycle pulse after the last slot of every frame
//   pend_valid  out  pending buffer holds uncommitted data
module disp_scan_mux
    import disp_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int GUARD       = 2,
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        load,
    input  logic [DIG_W*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]       blank_in,
    output logic [DIG_W-1:0]            dig_out,
    output logic [NUM_DIGITS-1:0]       an_n,
    output logic                        frame_done,
    output logic                        pend_valid
);

    logic [IW-1:0] idx;
    logic          in_guard;
    logic          slot_end;
    logic          frame_end;

    scan_prescaler #(
        .REFRESH_DIV (REFRESH_DIV),
        .NUM_DIGITS  (NUM_DIGITS),
        .GUARD       (GUARD)
    ) u_presc (
        .clk       (clk),
        .rst_n     (rst_n),
        .idx       (idx),
        .in_guard  (in_guard),
        .slot_end  (slot_end),
        .frame_end (frame_end)
    );

    logic [NUM_DIGITS-1:0][DIG_W-1:0] act_code;
    logic [NUM_DIGITS-1:0]            act_blank;
    logic [NUM_DIGITS-1:0][DIG_W-1:0] pend_code;
    logic [NUM_DIGITS-1:0]            pend_blank;

    logic [DIG_W-1:0]      cur_code_p0;
    logic                  lit_p0;
    logic [DIG_W-1:0]      dig_p0;
    logic [NUM_DIGITS-1:0] an_p0;

    // Stage p0: slot state of the current cycle, from the active buffer.
    always_comb begin
        cur_code_p0  = act_code[idx];
        lit_p0       = !in_guard && !act_blank[idx] && code_legal(cur_code_p0);
        dig_p0       = lit_p0 ? cur_code_p0 : CODE_BLANK_OUT;
        an_p0        = '1;
        an_p0[idx]   = ~lit_p0;
    end

    // Stage p1: registered outputs plus buffer/commit state.
    // In the commit cycle the active buffer takes the pending data held
    // before this edge; a simultaneous load refills pending for next frame.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            act_code   <= '0;
            act_blank  <= '1;
            pend_code  <= '0;
            pend_blank <= '0;
            pend_valid <= 1'b0;
            dig_out    <= CODE_BLANK_OUT;
            an_n       <= '1;
            frame_done <= 1'b0;
        end else begin
            if (frame_end && pend_valid) begin
                act_code  <= pend_code;
                act_blank <= pend_blank;
            end
            if (load) begin
                pend_code  <= digits_in;
                pend_blank <= blank_in;
                pend_valid <= 1'b1;
            end else if (frame_end) begin
                pend_valid <= 1'b0;
            end
            dig_out    <= dig_p0;
            an_n       <= an_p0;
            frame_done <= frame_end;
        end
    end

    // slot_end is only needed inside the prescaler's frame_end term.
    logic unused_ok;
    assign unused_ok = slot_end;

endmodule
